// File: rtl/dp_seq_pkg.sv
// Shared definitions for the datapath sequencer: state encoding, microword layout
// and the fixed program ROM contents.
package dp_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PROG_STEPS = 8;
  localparam int NUM_PROGS  = 4;

  // Microword: {END, W[2:0], CE[3:0], SEL[1:0], S[2:0]}
  localparam int UW_W    = 13;
  localparam int END_BIT = 12;
  localparam int W_LSB   = 9;
  localparam int W_W     = 3;
  localparam int CE_LSB  = 5;
  localparam int CE_W    = 4;
  localparam int SEL_LSB = 3;
  localparam int SEL_W   = 2;
  localparam int S_LSB   = 0;
  localparam int S_W     = 3;

  // Program 3 is reserved: no END word, so it runs every step and flags ERR.
  localparam logic [UW_W-1:0] PROG [NUM_PROGS][PROG_STEPS] = '{
    '{13'b0_000_0011_00_000, 13'b0_000_1000_00_010, 13'b0_000_1000_01_001,
      13'b1_100_0100_00_000, 13'b0, 13'b0, 13'b0, 13'b0},
    '{13'b0_000_0011_00_000, 13'b0_000_1000_00_011, 13'b1_010_0100_00_000,
      13'b0, 13'b0, 13'b0, 13'b0, 13'b0},
    '{13'b0_000_0001_00_000, 13'b0_000_1000_10_100, 13'b1_001_0100_00_000,
      13'b0, 13'b0, 13'b0, 13'b0, 13'b0},
    '{13'b0, 13'b0, 13'b0, 13'b0, 13'b0, 13'b0, 13'b0, 13'b0}
  };

endpackage

// File: rtl/dp_seq_rom.sv
// Combinational microprogram ROM: (program select, step) -> microword.
module dp_seq_rom
  import dp_seq_pkg::*;
#(
  parameter int STEP_W = $clog2(PROG_STEPS)
) (
  input  logic [1:0]        opsel,
  input  logic [STEP_W-1:0] step,
  output logic [UW_W-1:0]   uword
);

  assign uword = PROG[opsel][step];

endmodule

// File: rtl/dp_sequencer.sv
// Microcoded sequencer for the register/ALU datapath: clears the datapath, steps a
// fixed microprogram selected at START, pulses DONE, and flags runaway programs.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter  int MAX_STEPS = PROG_STEPS,
  localparam int STEP_W    = $clog2(MAX_STEPS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        OPSEL,
  input  logic              STALL,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [STEP_W-1:0] STEP,
  output logic              CLR,
  output logic [W_W-1:0]    W,
  output logic [CE_W-1:0]   CE,
  output logic [SEL_W-1:0]  SEL,
  output logic [S_W-1:0]    S
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [1:0]          opsel_q, opsel_d;
  logic                err_q, err_d;
  logic [UW_W-1:0]     uw_nxt;
  logic                run_d;
  logic                stall_mask;

  logic                end_p0;
  logic                busy_p0;
  logic                done_p0;
  logic                clr_p0;
  logic [W_W-1:0]      w_p0;
  logic [CE_W-1:0]     ce_p0;
  logic [SEL_W-1:0]    sel_p0;
  logic [S_W-1:0]      s_p0;

  // The ROM is addressed with the next program/step so every control output
  // can come straight from a register.
  dp_seq_rom #(
    .STEP_W (STEP_W)
  ) u_rom (
    .opsel (opsel_d),
    .step  (step_d),
    .uword (uw_nxt)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    opsel_d = opsel_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLEAR;
          opsel_d = OPSEL;
          err_d   = 1'b0;
          step_d  = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        step_d  = '0;
      end
      S_RUN: begin
        if (!STALL) begin
          if (end_p0) begin
            state_d = S_DONE;
          end else if (step_q == LAST_STEP) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            step_d  = step_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign run_d = (state_d == S_RUN);

  // Stage p0: control state and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      opsel_q <= '0;
      err_q   <= 1'b0;
      end_p0  <= 1'b0;
      busy_p0 <= 1'b0;
      done_p0 <= 1'b0;
      clr_p0  <= 1'b0;
      w_p0    <= '0;
      ce_p0   <= '0;
      sel_p0  <= '0;
      s_p0    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      opsel_q <= opsel_d;
      err_q   <= err_d;
      end_p0  <= run_d & uw_nxt[END_BIT];
      busy_p0 <= (state_d != S_IDLE);
      done_p0 <= (state_d == S_DONE);
      clr_p0  <= (state_d == S_CLEAR);
      w_p0    <= run_d ? uw_nxt[W_LSB +: W_W]     : '0;
      ce_p0   <= run_d ? uw_nxt[CE_LSB +: CE_W]   : '0;
      sel_p0  <= run_d ? uw_nxt[SEL_LSB +: SEL_W] : '0;
      s_p0    <= run_d ? uw_nxt[S_LSB +: S_W]     : '0;
    end
  end

  // A stalled wait state must not write or clock any register.
  assign stall_mask = STALL && (state_q == S_RUN);

  assign BUSY = busy_p0;
  assign DONE = done_p0;
  assign ERR  = err_q;
  assign STEP = step_q;
  assign CLR  = clr_p0;
  assign W    = w_p0  & ~{W_W{stall_mask}};
  assign CE   = ce_p0 & ~{CE_W{stall_mask}};
  assign SEL  = sel_p0;
  assign S    = s_p0;

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer: per-cycle output vectors checked against
// hand-computed expectations.
module tb_dp_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [1:0] OPSEL;
  logic       STALL;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [2:0] STEP;
  logic       CLR;
  logic [2:0] W;
  logic [3:0] CE;
  logic [1:0] SEL;
  logic [2:0] S;

  int total = 0;
  int bad   = 0;

  dp_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .OPSEL (OPSEL),
    .STALL (STALL),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR),
    .STEP  (STEP),
    .CLR   (CLR),
    .W     (W),
    .CE    (CE),
    .SEL   (SEL),
    .S     (S)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed as {BUSY, DONE, ERR, STEP, CLR, W, CE, SEL, S}
  function automatic logic [31:0] ex(input logic busy, input logic done, input logic err,
                                     input logic [2:0] step, input logic clr,
                                     input logic [2:0] w, input logic [3:0] ce,
                                     input logic [1:0] sel, input logic [2:0] s);
    return {13'b0, busy, done, err, step, clr, w, ce, sel, s};
  endfunction

  function automatic logic [31:0] obs_now();
    return {13'b0, BUSY, DONE, ERR, STEP, CLR, W, CE, SEL, S};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic tick_chk(input string tag, input logic [31:0] e);
    tick();
    chk(tag, obs_now(), e);
  endtask

  // Runs program 3 through CLEAR, all eight empty steps and into the DONE cycle.
  task automatic p3_run(input string tag);
    OPSEL = 2'd3;
    START = 1'b1;
    tick_chk({tag, " clr"}, ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    for (int i = 0; i < 8; i++)
      tick_chk({tag, " step"}, ex(1, 0, 0, 3'(i), 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    tick_chk({tag, " done"}, ex(1, 1, 1, 3'd7, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    STALL = 1'b0;
    OPSEL = 2'd0;
    #12;
    chk("reset state", obs_now(), 32'd0);
    RESET = 1'b0;

    // Program 0, no stall
    OPSEL = 2'd0;
    START = 1'b1;
    tick_chk("p0 clr", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    tick_chk("p0 s0", ex(1, 0, 0, 3'd0, 0, 3'b000, 4'b0011, 2'b00, 3'b000));
    tick_chk("p0 s1", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b1000, 2'b00, 3'b010));
    tick_chk("p0 s2", ex(1, 0, 0, 3'd2, 0, 3'b000, 4'b1000, 2'b01, 3'b001));
    tick_chk("p0 s3", ex(1, 0, 0, 3'd3, 0, 3'b100, 4'b0100, 2'b00, 3'b000));
    tick_chk("p0 done", ex(1, 1, 0, 3'd3, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    tick_chk("p0 idle", 32'd0);

    // Program 1 with a two-cycle stall on step 1
    OPSEL = 2'd1;
    START = 1'b1;
    tick_chk("p1 clr", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    tick_chk("p1 s0", ex(1, 0, 0, 3'd0, 0, 3'b000, 4'b0011, 2'b00, 3'b000));
    tick_chk("p1 s1", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b1000, 2'b00, 3'b011));
    STALL = 1'b1;
    #1;
    chk("p1 stall mask", obs_now(), ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b0000, 2'b00, 3'b011));
    tick_chk("p1 stall hold a", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b0000, 2'b00, 3'b011));
    tick_chk("p1 stall hold b", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b0000, 2'b00, 3'b011));
    STALL = 1'b0;
    #1;
    chk("p1 unmask", obs_now(), ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b1000, 2'b00, 3'b011));
    tick_chk("p1 s2", ex(1, 0, 0, 3'd2, 0, 3'b010, 4'b0100, 2'b00, 3'b000));
    tick_chk("p1 done", ex(1, 1, 0, 3'd2, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    tick_chk("p1 idle", 32'd0);

    // Program 2 with START and OPSEL disturbed while busy
    OPSEL = 2'd2;
    START = 1'b1;
    tick_chk("p2 clr", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    OPSEL = 2'd1;
    tick_chk("p2 s0", ex(1, 0, 0, 3'd0, 0, 3'b000, 4'b0001, 2'b00, 3'b000));
    OPSEL = 2'd3;
    tick_chk("p2 s1", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b1000, 2'b10, 3'b100));
    OPSEL = 2'd0;
    tick_chk("p2 s2", ex(1, 0, 0, 3'd2, 0, 3'b001, 4'b0100, 2'b00, 3'b000));
    tick_chk("p2 done", ex(1, 1, 0, 3'd2, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    tick_chk("p2 idle", 32'd0);
    tick_chk("p2 stay idle", 32'd0);

    // Program 3 runs away and sets ERR; next START clears it
    p3_run("p3a");
    tick_chk("p3a idle err", ex(0, 0, 1, 3'd0, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    OPSEL = 2'd0;
    START = 1'b1;
    tick_chk("err clear clr", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    repeat (5) tick();
    tick_chk("err clear idle", 32'd0);

    // Reset in the DONE cycle of a runaway program clears everything including ERR
    p3_run("p3b");
    RESET = 1'b1;
    #1;
    chk("p3b reset", obs_now(), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    tick_chk("p3b idle", 32'd0);

    // Reset mid program 0, step 2
    OPSEL = 2'd0;
    START = 1'b1;
    tick_chk("rst clr", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    tick();
    tick();
    tick_chk("rst s2", ex(1, 0, 0, 3'd2, 0, 3'b000, 4'b1000, 2'b01, 3'b001));
    RESET = 1'b1;
    #1;
    chk("rst async", obs_now(), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    tick_chk("rst idle", 32'd0);
    tick_chk("rst no done", 32'd0);

    // START held high: back-to-back program 1 runs with one IDLE cycle between
    OPSEL = 2'd1;
    START = 1'b1;
    tick_chk("b2b clr a", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    tick_chk("b2b s0 a", ex(1, 0, 0, 3'd0, 0, 3'b000, 4'b0011, 2'b00, 3'b000));
    tick_chk("b2b s1 a", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b1000, 2'b00, 3'b011));
    tick_chk("b2b s2 a", ex(1, 0, 0, 3'd2, 0, 3'b010, 4'b0100, 2'b00, 3'b000));
    tick_chk("b2b done a", ex(1, 1, 0, 3'd2, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    tick_chk("b2b gap", 32'd0);
    tick_chk("b2b clr b", ex(1, 0, 0, 3'd0, 1, 3'b000, 4'b0000, 2'b00, 3'b000));
    START = 1'b0;
    tick_chk("b2b s0 b", ex(1, 0, 0, 3'd0, 0, 3'b000, 4'b0011, 2'b00, 3'b000));
    tick_chk("b2b s1 b", ex(1, 0, 0, 3'd1, 0, 3'b000, 4'b1000, 2'b00, 3'b011));
    tick_chk("b2b s2 b", ex(1, 0, 0, 3'd2, 0, 3'b010, 4'b0100, 2'b00, 3'b000));
    tick_chk("b2b done b", ex(1, 1, 0, 3'd2, 0, 3'b000, 4'b0000, 2'b00, 3'b000));
    tick_chk("b2b idle", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
